// File: rtl/data_dist_pkg.sv
// Shared definitions for the data distributor.
// Contents:
//   DefaultWidth / DefaultNOut  default data width and channel count
//   clog2                       select-width helper (minimum 1 bit)
//   slice_lo                    low bit of channel idx on the packed out_data bus
package data_dist_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultNOut  = 4;

  // Ceiling log2, never below 1 so a select bus always has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/data_distributor_if.sv
// Bundle of the producer-side and consumer-side signals of the data distributor.
// Modports:
//   master  testbench / environment: drives the input beat, rr_mode and out_ready
//   slave   distributor: drives in_ready, out_data, out_valid, rr_ptr, sel_err
interface data_distributor_if
  import data_dist_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned N_OUT = DefaultNOut
) ();

  localparam int unsigned SEL_W = clog2(N_OUT);

  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_valid;
  logic                   in_ready;
  logic                   rr_mode;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic [SEL_W-1:0]       rr_ptr;
  logic                   sel_err;

  modport master (
    output in_data, in_sel, in_valid, rr_mode, out_ready,
    input  in_ready, out_data, out_valid, rr_ptr, sel_err
  );

  modport slave (
    input  in_data, in_sel, in_valid, rr_mode, out_ready,
    output in_ready, out_data, out_valid, rr_ptr, sel_err
  );

endinterface

// File: rtl/dist_slot.sv
// One-entry output register of a distributor channel.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        write d this cycle (takes priority over drain)
//   d           data to load
//   ready       consumer takes the held beat this cycle
//   q           held data (kept after drain, don't-care while !valid)
//   valid       entry holds a beat
module dist_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  // Load wins over drain, so a same-cycle drain/refill keeps valid high with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= d;
      valid_q <= 1'b1;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/data_distributor.sv
// Registered 1-to-N data distributor.
// Routes one valid/ready input stream to one of N_OUT one-entry output channels, chosen by
// in_sel (directed) or by an internal round-robin pointer (rr_mode=1).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         data_distributor_if slave modport:
//                 in_data/in_sel/in_valid/in_ready  input stream and target select
//                 rr_mode                           1 = round-robin targeting
//                 out_data/out_valid/out_ready      per-channel output streams
//                 rr_ptr                            current round-robin target
//                 sel_err                           one-cycle pulse per discarded bad-select beat
module data_distributor
  import data_dist_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned N_OUT = DefaultNOut
) (
  input  logic              clk,
  input  logic              rst_n,
  data_distributor_if.slave bus
);

  localparam int unsigned SEL_W = clog2(N_OUT);
  localparam int unsigned N_SEL = 1 << SEL_W;

  logic [SEL_W-1:0] target;
  logic             target_ok;
  logic [N_SEL-1:0] slot_free;
  logic             accept;
  logic [N_OUT-1:0] load;
  logic [N_OUT-1:0] slot_valid;
  logic [WIDTH-1:0] slot_q [N_OUT];

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             sel_err_q, sel_err_d;

  assign target    = bus.rr_mode ? rr_ptr_q : bus.in_sel;
  assign target_ok = 32'(target) < N_OUT;

  // Codes past N_OUT-1 read as free, so a bad select is always accepted (and then dropped).
  always_comb begin
    slot_free = '1;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      slot_free[i] = !slot_valid[i] || bus.out_ready[i];
    end
  end

  assign bus.in_ready = slot_free[target];
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      load[i] = accept && target_ok && (32'(target) == i);
    end
  end

  // The pointer is always in range, so in rr_mode every accept lands on a real channel.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && bus.rr_mode) begin
      rr_ptr_d = (rr_ptr_q == SEL_W'(N_OUT - 1)) ? '0 : rr_ptr_q + 1'b1;
    end
  end

  assign sel_err_d = accept && !target_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      sel_err_q <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      sel_err_q <= sel_err_d;
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    dist_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[i]),
      .d     (bus.in_data),
      .ready (bus.out_ready[i]),
      .q     (slot_q[i]),
      .valid (slot_valid[i])
    );

    assign bus.out_data[slice_lo(i, WIDTH) +: WIDTH] = slot_q[i];
  end

  assign bus.out_valid = slot_valid;
  assign bus.rr_ptr    = rr_ptr_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_data_distributor.sv
// Self-checking bench for data_distributor: a 4-channel instance checked against a
// per-channel beat-holding model (directed steps plus random traffic), and a 3-channel
// instance for the out-of-range select path.
module tb_data_distributor;
  import data_dist_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned N3 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_distributor_if #(.WIDTH(W), .N_OUT(N))  bus4 ();
  data_distributor_if #(.WIDTH(W), .N_OUT(N3)) bus3 ();

  data_distributor #(.WIDTH(W), .N_OUT(N)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  data_distributor #(.WIDTH(W), .N_OUT(N3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model of the 4-channel instance: what each channel currently holds and where RR points.
  bit         m_valid [N];
  logic [7:0] m_data  [N];
  int         m_ptr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0;
      m_data[i]  = '0;
    end
    m_ptr = 0;
  endtask

  function automatic logic [N-1:0] model_valid_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_valid[i];
    return v;
  endfunction

  // Called at posedge+1 with inputs already driven; advances one clock.
  task automatic cycle();
    int t;
    bit rdy;
    logic [31:0] od;
    #1;
    t   = bus4.rr_mode ? m_ptr : int'(bus4.in_sel);
    rdy = !m_valid[t] || bus4.out_ready[t];
    check("in_ready", bus4.in_ready, rdy);
    for (int i = 0; i < N; i++) begin
      if (bus4.out_ready[i]) m_valid[i] = 0;
    end
    if (bus4.in_valid && rdy) begin
      m_valid[t] = 1;
      m_data[t]  = bus4.in_data;
      if (bus4.rr_mode) m_ptr = (m_ptr + 1) % N;
    end
    @(posedge clk);
    #1;
    check("out_valid", bus4.out_valid, model_valid_vec());
    check("rr_ptr", bus4.rr_ptr, m_ptr);
    check("sel_err4", bus4.sel_err, 0);
    od = bus4.out_data;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i]) check($sformatf("out_data[%0d]", i), od[i*8 +: 8], m_data[i]);
    end
  endtask

  initial begin
    logic [31:0] od;
    logic [23:0] od3;

    bus4.in_data = '0; bus4.in_sel = '0; bus4.in_valid = 0; bus4.rr_mode = 0; bus4.out_ready = '0;
    bus3.in_data = '0; bus3.in_sel = '0; bus3.in_valid = 0; bus3.rr_mode = 0; bus3.out_ready = '0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", bus4.out_valid, 0);
    check("rst_rr_ptr", bus4.rr_ptr, 0);
    check("rst_sel_err", bus4.sel_err, 0);
    check("rst_out_valid3", bus3.out_valid, 0);

    // Reset mid-stream: fill channels 0,1 by RR and 3 directed, consumers stalled.
    bus4.out_ready = 4'b0000;
    bus4.rr_mode = 1; bus4.in_valid = 1;
    bus4.in_data = 8'hAA; cycle();
    bus4.in_data = 8'hBB; cycle();
    bus4.rr_mode = 0; bus4.in_sel = 2'd3; bus4.in_data = 8'hCC; cycle();
    bus4.in_valid = 0;
    check("pre_rst_valid", bus4.out_valid, 4'b1011);
    check("pre_rst_ptr", bus4.rr_ptr, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus4.out_valid, 0);
    check("async_rst_ptr", bus4.rr_ptr, 0);
    check("async_rst_err", bus4.sel_err, 0);
    check("async_rst_data", bus4.out_data, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", bus4.in_ready, 1);

    // Directed routing to channel 2.
    bus4.out_ready = 4'hF; bus4.in_sel = 2'd2; bus4.in_data = 8'hA5; bus4.in_valid = 1;
    cycle();
    bus4.in_valid = 0;
    od = bus4.out_data;
    check("dir_valid", bus4.out_valid, 4'b0100);
    check("dir_data", od[23:16], 8'hA5);
    cycle();
    check("dir_drained", bus4.out_valid, 0);

    // Backpressure on channel 1, then drain and refill in the same cycle.
    bus4.out_ready = 4'b1101; bus4.in_sel = 2'd1; bus4.in_valid = 1;
    bus4.in_data = 8'h11; cycle();
    bus4.in_data = 8'h22; cycle();
    cycle();
    #1;
    check("bp_in_ready", bus4.in_ready, 0);
    bus4.out_ready = 4'hF;
    cycle();
    bus4.in_valid = 0;
    od = bus4.out_data;
    check("bp_refill_data", od[15:8], 8'h22);
    check("bp_refill_valid", bus4.out_valid[1], 1);
    cycle();

    // Round-robin across all channels.
    bus4.rr_mode = 1; bus4.in_valid = 1;
    for (int k = 0; k < 6; k++) begin
      bus4.in_data = 8'h10 + 8'(k);
      cycle();
      check("rr_land", bus4.out_valid, 4'b0001 << (k % 4));
    end
    bus4.in_valid = 0;
    check("rr_end_ptr", bus4.rr_ptr, 2);
    cycle();

    // Round-robin stall: channel 2 fills and is not drained; RR comes back round to it.
    bus4.out_ready = 4'b1011; bus4.in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      bus4.in_data = 8'h30 + 8'(k);
      cycle();
    end
    bus4.in_data = 8'h34;
    cycle();
    cycle();
    #1;
    check("rr_stall_ready", bus4.in_ready, 0);
    check("rr_stall_ptr", bus4.rr_ptr, 2);
    bus4.out_ready = 4'hF;
    cycle();
    bus4.in_valid = 0;
    od = bus4.out_data;
    check("rr_release_data", od[23:16], 8'h34);
    check("rr_release_ptr", bus4.rr_ptr, 3);
    cycle();

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      bus4.in_valid  = 1'($urandom_range(0, 1));
      bus4.in_data   = 8'($urandom);
      bus4.in_sel    = 2'($urandom);
      bus4.rr_mode   = ($urandom_range(0, 3) == 0);
      bus4.out_ready = 4'($urandom);
      cycle();
    end
    bus4.in_valid = 0;
    bus4.out_ready = 4'hF;
    cycle();

    // Out-of-range select on the 3-channel instance.
    bus3.out_ready = 3'b000; bus3.rr_mode = 0;
    bus3.in_sel = 2'd2; bus3.in_data = 8'h5C; bus3.in_valid = 1;
    #1;
    check("n3_good_ready", bus3.in_ready, 1);
    @(posedge clk); #1;
    od3 = bus3.out_data;
    check("n3_good_valid", bus3.out_valid, 3'b100);
    check("n3_good_data", od3[23:16], 8'h5C);
    check("n3_good_err", bus3.sel_err, 0);
    bus3.in_valid = 0;
    #1;
    check("n3_full_ready", bus3.in_ready, 0);
    bus3.in_sel = 2'd3; bus3.in_data = 8'h7E; bus3.in_valid = 1;
    #1;
    check("n3_bad_ready", bus3.in_ready, 1);
    @(posedge clk); #1;
    od3 = bus3.out_data;
    check("n3_bad_valid", bus3.out_valid, 3'b100);
    check("n3_bad_err", bus3.sel_err, 1);
    check("n3_bad_keep", od3[23:16], 8'h5C);
    bus3.in_valid = 0;
    @(posedge clk); #1;
    check("n3_err_pulse", bus3.sel_err, 0);
    bus3.in_valid = 1;
    @(posedge clk); #1;
    check("n3_b2b_err1", bus3.sel_err, 1);
    @(posedge clk); #1;
    check("n3_b2b_err2", bus3.sel_err, 1);
    bus3.in_valid = 0;
    @(posedge clk); #1;
    check("n3_b2b_clear", bus3.sel_err, 0);
    check("n3_b2b_valid", bus3.out_valid, 3'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
